// File: rtl/arc_micro_sequencer_pkg.sv
// Shared definitions for the ARC micro-sequencer: FSM states, branch condition codes,
// microinstruction field positions and the reset microaddress.
package arc_micro_sequencer_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'd0,
        COND_JN     = 3'd1,
        COND_JZ     = 3'd2,
        COND_JV     = 3'd3,
        COND_JC     = 3'd4,
        COND_JIR13  = 3'd5,
        COND_JMP    = 3'd6,
        COND_DECODE = 3'd7
    } cond_t;

    // Microword layout, MSB first: A AMUX B BMUX C CMUX RD WR ALU COND JADDR
    localparam int MIR_A_HI     = 40;
    localparam int MIR_A_LO     = 35;
    localparam int MIR_AMUX     = 34;
    localparam int MIR_B_HI     = 33;
    localparam int MIR_B_LO     = 28;
    localparam int MIR_BMUX     = 27;
    localparam int MIR_C_HI     = 26;
    localparam int MIR_C_LO     = 21;
    localparam int MIR_CMUX     = 20;
    localparam int MIR_RD       = 19;
    localparam int MIR_WR       = 18;
    localparam int MIR_ALU_HI   = 17;
    localparam int MIR_ALU_LO   = 14;
    localparam int MIR_COND_HI  = 13;
    localparam int MIR_COND_LO  = 11;
    localparam int MIR_JADDR_HI = 10;
    localparam int MIR_JADDR_LO = 0;

    localparam logic [10:0] RESET_UADDR = 11'd0;

endpackage

// File: rtl/arc_micro_sequencer_next_addr.sv
// Combinational next-microaddress selection from COND, PSR flags {n,z,v,c} and IR fields.
module arc_next_addr
    import arc_micro_sequencer_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic [AW-1:0] upc,
    input  logic [2:0]    cond,
    input  logic [AW-1:0] jaddr,
    input  logic [3:0]    flags,
    input  logic [1:0]    ir_op,
    input  logic [5:0]    ir_op3,
    input  logic          ir_bit13,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] seq_addr;
    logic          take;

    // Sequential successor wraps naturally at the top of the microstore
    assign seq_addr = upc + 1'b1;

    always_comb begin
        take      = 1'b0;
        next_addr = seq_addr;
        case (cond_t'(cond))
            COND_NEXT:   take = 1'b0;
            COND_JN:     take = flags[3];
            COND_JZ:     take = flags[2];
            COND_JV:     take = flags[1];
            COND_JC:     take = flags[0];
            COND_JIR13:  take = ir_bit13;
            COND_JMP:    take = 1'b1;
            COND_DECODE: next_addr = AW'({1'b1, ir_op, ir_op3, 2'b00});
            default:     take = 1'b0;
        endcase
        if (take) begin
            next_addr = jaddr;
        end
    end

endmodule

// File: rtl/arc_micro_sequencer.sv
// ARC micro-sequencer: fetch/execute/wait FSM around an external microcode ROM.
// Optional single-step control is enabled by defining MSEQ_STEP_EN.
module arc_micro_sequencer
    import arc_micro_sequencer_pkg::*;
#(
    parameter int ROM_BUS_In  = 11,
    parameter int ROM_BUS_Out = 41
) (
    input  logic                   MSEQ_CLOCK_50,
    input  logic                   MSEQ_RESET_InHigh,
    output logic [ROM_BUS_In-1:0]  MSEQ_RomAddr_Out,
    input  logic [ROM_BUS_Out-1:0] MSEQ_RomData_In,
    input  logic [31:0]            MSEQ_IR_In,
    input  logic [3:0]             MSEQ_Flags_In,
    input  logic                   MSEQ_MemAck_In,
`ifdef MSEQ_STEP_EN
    input  logic                   MSEQ_Step_In,
`endif
    output logic [ROM_BUS_Out-1:0] MSEQ_MIR_Out,
    output logic                   MSEQ_MIRValid_Out
);

    state_t                  state_q, state_d;
    logic [ROM_BUS_In-1:0]   upc_q, upc_d;
    logic [ROM_BUS_In-1:0]   wait_addr_q;
    logic [ROM_BUS_Out-1:0]  mir_q;
    logic [ROM_BUS_In-1:0]   next_addr;
    logic                    mir_load;
    logic                    wait_load;
    logic                    fetch_go;
    logic                    mem_req;

`ifdef MSEQ_STEP_EN
    assign fetch_go = MSEQ_Step_In;
`else
    assign fetch_go = 1'b1;
`endif

    // RD and WR together still form a single memory access
    assign mem_req = mir_q[MIR_RD] | mir_q[MIR_WR];

    arc_next_addr #(
        .AW(ROM_BUS_In)
    ) u_next_addr (
        .upc       (upc_q),
        .cond      (mir_q[MIR_COND_HI:MIR_COND_LO]),
        .jaddr     (mir_q[MIR_JADDR_HI:MIR_JADDR_LO]),
        .flags     (MSEQ_Flags_In),
        .ir_op     (MSEQ_IR_In[31:30]),
        .ir_op3    (MSEQ_IR_In[24:19]),
        .ir_bit13  (MSEQ_IR_In[13]),
        .next_addr (next_addr)
    );

    always_comb begin
        state_d           = state_q;
        upc_d             = upc_q;
        mir_load          = 1'b0;
        wait_load         = 1'b0;
        MSEQ_MIRValid_Out = 1'b0;
        case (state_q)
            S_RESET: begin
                upc_d   = ROM_BUS_In'(RESET_UADDR);
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_go) begin
                    mir_load = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                MSEQ_MIRValid_Out = 1'b1;
                // Branch decision is frozen here so flag/IR changes while waiting cannot alter it
                if (mem_req) begin
                    wait_load = 1'b1;
                    state_d   = S_WAIT;
                end else begin
                    upc_d   = next_addr;
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                if (MSEQ_MemAck_In) begin
                    upc_d   = wait_addr_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge MSEQ_CLOCK_50 or posedge MSEQ_RESET_InHigh) begin
        if (MSEQ_RESET_InHigh) begin
            state_q     <= S_RESET;
            upc_q       <= ROM_BUS_In'(RESET_UADDR);
            wait_addr_q <= ROM_BUS_In'(RESET_UADDR);
            mir_q       <= '0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            if (wait_load) begin
                wait_addr_q <= next_addr;
            end
            if (mir_load) begin
                mir_q <= MSEQ_RomData_In;
            end
        end
    end

    assign MSEQ_RomAddr_Out = upc_q;
    assign MSEQ_MIR_Out     = mir_q;

endmodule

// File: tb/tb_arc_micro_sequencer.sv
// Self-checking bench for arc_micro_sequencer: directed next-address table, multi-cycle
// corner sequences and a randomized run against a behavioural microprogram model.
module tb_arc_micro_sequencer;

    logic        clk;
    logic        rst;
    logic [10:0] addr;
    logic [40:0] rom_data;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic        ack;
    logic [40:0] mir;
    logic        valid;
`ifdef MSEQ_STEP_EN
    logic        step_in;
`endif

    logic [40:0] rom [2048];
    logic [10:0] exp_pc;
    int          n_cmp;
    int          n_err;

    assign rom_data = rom[addr];

    arc_micro_sequencer #(
        .ROM_BUS_In (11),
        .ROM_BUS_Out(41)
    ) dut (
        .MSEQ_CLOCK_50    (clk),
        .MSEQ_RESET_InHigh(rst),
        .MSEQ_RomAddr_Out (addr),
        .MSEQ_RomData_In  (rom_data),
        .MSEQ_IR_In       (ir),
        .MSEQ_Flags_In    (flags),
        .MSEQ_MemAck_In   (ack),
`ifdef MSEQ_STEP_EN
        .MSEQ_Step_In     (step_in),
`endif
        .MSEQ_MIR_Out     (mir),
        .MSEQ_MIRValid_Out(valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  cond;
        logic [10:0] jaddr;
        logic [3:0]  flags;
        logic [31:0] ir;
        logic [10:0] pc;
        logic [10:0] exp_next;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [40:0] mk(input logic rd, input logic wr,
                                       input logic [2:0] cond, input logic [10:0] ja);
        logic [63:0] r;
        logic [40:0] w;
        r        = {$urandom, $urandom};
        w        = r[40:0];
        w[19]    = rd;
        w[18]    = wr;
        w[13:11] = cond;
        w[10:0]  = ja;
        return w;
    endfunction

    // Next microaddress straight from the branch rules, using integer arithmetic
    function automatic logic [10:0] ref_next(input logic [10:0] pc, input logic [40:0] w,
                                             input logic [3:0] f, input logic [31:0] i);
        int   seq, tgt, c;
        logic take;
        seq  = (int'(pc) + 1) % 2048;
        tgt  = int'(w[10:0]);
        c    = int'(w[13:11]);
        take = 1'b0;
        case (c)
            1: take = f[3];
            2: take = f[2];
            3: take = f[1];
            4: take = f[0];
            5: take = i[13];
            6: take = 1'b1;
            7: return 11'(1024 + int'(i[31:30]) * 256 + int'(i[24:19]) * 4);
            default: take = 1'b0;
        endcase
        return take ? 11'(tgt) : 11'(seq);
    endfunction

    // Reset, then walk S_RESET and S_FETCH; returns positioned in the first execute cycle
    task automatic do_reset();
        rst = 1'b1;
        ack = 1'b0;
        step();
        step();
        chk("rst_addr", addr, 0);
        chk("rst_mir", mir, 0);
        chk("rst_valid", valid, 0);
        rst = 1'b0;
        chk("rel_valid", valid, 0);
        step();
        chk("fetch0_valid", valid, 0);
        chk("fetch0_addr", addr, 0);
        step();
        exp_pc = 11'd0;
    endtask

    // Entered in an execute cycle of exp_pc; leaves in the execute cycle of the next one
    task automatic exec_one(input int n_wait);
        logic [40:0] w;
        logic [10:0] nxt;
        logic        mem;
        w = rom[exp_pc];
        chk("exec_valid", valid, 1);
        chk("exec_mir", mir, w);
        chk("exec_addr", addr, exp_pc);
        flags = 4'($urandom);
        ir    = $urandom;
        ack   = 1'($urandom);
        nxt   = ref_next(exp_pc, w, flags, ir);
        mem   = w[19] | w[18];
        step();
        if (mem) begin
            for (int k = 1; k <= n_wait; k++) begin
                chk("wait_valid", valid, 0);
                chk("wait_mir", mir, w);
                chk("wait_addr", addr, exp_pc);
                flags = 4'($urandom);
                ir    = $urandom;
                ack   = (k == n_wait);
                step();
            end
        end
        chk("fetch_valid", valid, 0);
        chk("fetch_addr", addr, nxt);
        ack   = 1'($urandom);
        flags = 4'($urandom);
        step();
        ack    = 1'b0;
        exp_pc = nxt;
    endtask

    initial begin
        vec_t vecs [14];
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        ack     = 1'b0;
        ir      = '0;
        flags   = '0;
        exp_pc  = '0;
`ifdef MSEQ_STEP_EN
        step_in = 1'b1;
`endif
        for (int a = 0; a < 2048; a++) rom[a] = mk(1'b0, 1'b0, 3'd0, 11'd0);

        vecs[0]  = '{3'd7, 11'd0,    4'b0000, 32'hC000_0000, 11'd20,   11'd1792};
        vecs[1]  = '{3'd7, 11'd0,    4'b1111, 32'h8080_0000, 11'd20,   11'd1600};
        vecs[2]  = '{3'd2, 11'd12,   4'b0100, 32'h0000_0000, 11'd8,    11'd12};
        vecs[3]  = '{3'd2, 11'd12,   4'b1011, 32'h0000_0000, 11'd8,    11'd9};
        vecs[4]  = '{3'd0, 11'd5,    4'b1111, 32'hFFFF_FFFF, 11'd2047, 11'd0};
        vecs[5]  = '{3'd1, 11'd300,  4'b1000, 32'h0000_0000, 11'd40,   11'd300};
        vecs[6]  = '{3'd1, 11'd300,  4'b0111, 32'h0000_0000, 11'd40,   11'd41};
        vecs[7]  = '{3'd3, 11'd77,   4'b0010, 32'h0000_0000, 11'd50,   11'd77};
        vecs[8]  = '{3'd3, 11'd77,   4'b1101, 32'h0000_0000, 11'd50,   11'd51};
        vecs[9]  = '{3'd4, 11'd1000, 4'b0001, 32'h0000_0000, 11'd60,   11'd1000};
        vecs[10] = '{3'd4, 11'd1000, 4'b1110, 32'h0000_0000, 11'd60,   11'd61};
        vecs[11] = '{3'd5, 11'd500,  4'b0000, 32'h0000_2000, 11'd70,   11'd500};
        vecs[12] = '{3'd5, 11'd500,  4'b1111, 32'hFFFF_DFFF, 11'd70,   11'd71};
        vecs[13] = '{3'd6, 11'd1234, 4'b0000, 32'h0000_0000, 11'd90,   11'd1234};

        // Sequential stepping from word 0: addresses 0,1,2,3 and valid every second cycle
        for (int a = 0; a < 4; a++) rom[a] = mk(1'b0, 1'b0, 3'd0, 11'($urandom));
        do_reset();
        for (int k = 0; k < 3; k++) exec_one(0);

        // Next-address table: jump from word 0 to the vector's address, execute it there
        for (int v = 0; v < 14; v++) begin
            rom[0]           = mk(1'b0, 1'b0, 3'd6, vecs[v].pc);
            rom[vecs[v].pc]  = mk(1'b0, 1'b0, vecs[v].cond, vecs[v].jaddr);
            do_reset();
            exec_one(0);
            chk($sformatf("vec%0d_valid", v), valid, 1);
            chk($sformatf("vec%0d_mir", v), mir, rom[vecs[v].pc]);
            flags = vecs[v].flags;
            ir    = vecs[v].ir;
            ack   = 1'b0;
            step();
            chk($sformatf("vec%0d_next", v), addr, vecs[v].exp_next);
        end

        // RD with ack three cycles later, then RD+WR released by one ack
        rom[0] = mk(1'b1, 1'b0, 3'd0, 11'd0);
        rom[1] = mk(1'b1, 1'b1, 3'd6, 11'd7);
        rom[7] = mk(1'b0, 1'b0, 3'd0, 11'd0);
        do_reset();
        exec_one(3);
        exec_one(1);
        exec_one(0);

        // Reset in the middle of a memory wait
        rom[0] = mk(1'b0, 1'b0, 3'd6, 11'd5);
        rom[5] = mk(1'b1, 1'b0, 3'd0, 11'd0);
        do_reset();
        exec_one(0);
        chk("mw_exec_valid", valid, 1);
        ack = 1'b0;
        step();
        chk("mw_wait_valid", valid, 0);
        chk("mw_wait_addr", addr, 5);
        #3 rst = 1'b1;
        #1;
        chk("mw_rst_addr", addr, 0);
        chk("mw_rst_mir", mir, 0);
        chk("mw_rst_valid", valid, 0);
        step();
        rst = 1'b0;
        chk("mw_rel_valid", valid, 0);
        step();
        chk("mw_fetch_addr", addr, 0);
        chk("mw_fetch_valid", valid, 0);
        step();
        exp_pc = 11'd0;
        exec_one(0);

        // Randomized microprogram
        for (int a = 0; a < 2048; a++)
            rom[a] = mk($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                        3'($urandom), 11'($urandom));
        do_reset();
        for (int k = 0; k < 400; k++) exec_one($urandom_range(1, 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
